alu_mc: RTL

//  Parametrised multi-cycle ALU for the ARC datapath: the next generation of the combinational ALU.

---
 rtl/alu_mc.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the ARC datapath.
//   Single-cycle functions (func 0-15) finish one cycle after start.
//   Unsigned MULCC/MULH/DIVCC/REMCC (func 16-19) run one step per cycle for W cycles.
//   Reserved functions (func 20-31) pass A through.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  op request; accepted only when not busy
//   func   function select, sampled with start
//   bus_a  operand A, sampled with start
//   bus_b  operand B, sampled with start
//   busy   iterative op in progress
//   done   one-cycle pulse; bus_c/psr valid this cycle
//   bus_c  registered result; held until the next done
//   psr    registered {N,Z,V,C}; updated only on done of a flag-setting op
module alu_mc #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [4:0]   func,
    input  logic [W-1:0] bus_a,
    input  logic [W-1:0] bus_b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] bus_c,
    output logic [3:0]   psr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic [W-1:0]     bus_c_q;
    logic [3:0]       psr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       op_q;
    // Shared iteration registers:
    //   multiply: opd_q = multiplicand, hi_q = partial product, lo_q = multiplier / low product
    //   divide:   opd_q = divisor,      hi_q = partial remainder, lo_q = dividend / quotient
    logic [W-1:0]     opd_q;
    logic [W-1:0]     hi_q;
    logic [W-1:0]     lo_q;
    logic [W-1:0]     hi_d;
    logic [W-1:0]     lo_d;

    // ------------------------------------------------------------------
    // Single-cycle function decode
    // ------------------------------------------------------------------
    logic [W:0]   add_sum;
    logic         add_cin_msb;
    logic [W-1:0] sc_res;
    logic         sc_cc;
    logic         sc_v;
    logic         sc_c;

    always_comb begin
        add_sum     = {1'b0, bus_a} + {1'b0, bus_b};
        // Carry into the MSB recovered from the MSB sum bit.
        add_cin_msb = bus_a[W-1] ^ bus_b[W-1] ^ add_sum[W-1];
        sc_res      = bus_a;
        sc_cc       = 1'b0;
        sc_v        = 1'b0;
        sc_c        = 1'b0;
        case (func)
            5'd0: begin
                sc_res = bus_a & bus_b;
                sc_cc  = 1'b1;
            end
            5'd1: begin
                sc_res = bus_a | bus_b;
                sc_cc  = 1'b1;
            end
            5'd2: begin
                sc_res = ~(bus_a | bus_b);
                sc_cc  = 1'b1;
            end
            5'd3: begin
                sc_res = add_sum[W-1:0];
                sc_cc  = 1'b1;
                sc_c   = add_sum[W];
                sc_v   = add_cin_msb ^ add_sum[W];
            end
            5'd5:    sc_res = bus_a & bus_b;
            5'd6:    sc_res = bus_a | bus_b;
            5'd7:    sc_res = ~(bus_a | bus_b);
            5'd8:    sc_res = add_sum[W-1:0];
            5'd11:   sc_res = {{(W-13){1'b0}}, bus_a[12:0]};
            5'd12:   sc_res = {{(W-13){bus_a[12]}}, bus_a[12:0]};
            5'd13:   sc_res = bus_a + W'(1);
            5'd14:   sc_res = bus_a + W'(4);
            5'd15:   sc_res = $signed(bus_a) >>> 5;
            default: sc_res = bus_a;
        endcase
    end

    // ------------------------------------------------------------------
    // One iteration step (shift-add multiply / restoring divide)
    // ------------------------------------------------------------------
    logic [W:0]   mul_sum;
    logic [W:0]   div_trial;
    logic [W:0]   div_diff;
    logic         div_ge;
    logic [W-1:0] fin_res;
    logic         fin_cc;
    logic         fin_v;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        div_trial = {hi_q, lo_q[W-1]};
        div_diff  = div_trial - {1'b0, opd_q};
        // The trial value stays below 2*divisor, so a borrow into bit W
        // means the divisor does not fit.
        div_ge    = ~div_diff[W];
        if (op_q[1]) begin
            hi_d = div_ge ? div_diff[W-1:0] : div_trial[W-1:0];
            lo_d = {lo_q[W-2:0], div_ge};
        end else begin
            hi_d = mul_sum[W:1];
            lo_d = {mul_sum[0], lo_q[W-1:1]};
        end
        // op 00 MULCC -> low, 01 MULH -> high, 10 DIVCC -> quotient, 11 REMCC -> remainder
        fin_res = op_q[0] ? hi_d : lo_d;
        fin_cc  = (op_q != 2'b01);
        fin_v   = op_q[1] ? (opd_q == '0) : (hi_d != '0);
        cnt_d   = cnt_q + CNT_W'(1);
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bus_c_q <= '0;
            psr_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            opd_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // FIN is the done cycle of an iterative op; it accepts a new
                // start exactly like IDLE so back-to-back issue works.
                S_IDLE, S_FIN: begin
                    state_q <= S_IDLE;
                    if (start) begin
                        if (func[4:2] == 3'b100) begin
                            state_q <= S_ITER;
                            busy_q  <= 1'b1;
                            op_q    <= func[1:0];
                            cnt_q   <= '0;
                            hi_q    <= '0;
                            opd_q   <= func[1] ? bus_b : bus_a;
                            lo_q    <= func[1] ? bus_a : bus_b;
                        end else begin
                            bus_c_q <= sc_res;
                            done_q  <= 1'b1;
                            if (sc_cc) begin
                                psr_q <= {sc_res[W-1], sc_res == '0, sc_v, sc_c};
                            end
                        end
                    end
                end
                S_ITER: begin
                    cnt_q <= cnt_d;
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    // The W-th step's result is written straight to bus_c so
                    // done lands in cycle W+1.
                    if (cnt_d == CNT_W'(W)) begin
                        state_q <= S_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bus_c_q <= fin_res;
                        if (fin_cc) begin
                            psr_q <= {fin_res[W-1], fin_res == '0, fin_v, 1'b0};
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign bus_c = bus_c_q;
    assign psr   = psr_q;

endmodule
